// File: rtl/pacman_input_pkg.sv
// Shared definitions for the Pac-Man PS/2 input path.
// Contents:
//   - scan-code constants: the E0/F0 prefixes, the four extended arrow
//     codes and the four WASD make codes
//   - scan_state_t : state encoding of the make/break decoder
//   - dir_t        : the currently held direction
//   - helpers that map a scan code to a direction and a direction to the
//     {up, down, left, right} output vector
// WASD decoding is only used when PACMAN_WASD_EN is defined; the codes live
// here unconditionally so both builds share one package.
package pacman_input_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Extended (E0-prefixed) arrow keys
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Non-extended WASD keys
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } scan_state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    function automatic dir_t arrow_dir(input logic [7:0] code);
        case (code)
            SC_UP:    return DIR_UP;
            SC_DOWN:  return DIR_DOWN;
            SC_LEFT:  return DIR_LEFT;
            SC_RIGHT: return DIR_RIGHT;
            default:  return DIR_NONE;
        endcase
    endfunction

    function automatic dir_t wasd_dir(input logic [7:0] code);
        case (code)
            SC_W:    return DIR_UP;
            SC_S:    return DIR_DOWN;
            SC_A:    return DIR_LEFT;
            SC_D:    return DIR_RIGHT;
            default: return DIR_NONE;
        endcase
    endfunction

    // Bit order {up, down, left, right}
    function automatic logic [3:0] dir_onehot(input dir_t dir);
        case (dir)
            DIR_UP:    return 4'b1000;
            DIR_DOWN:  return 4'b0100;
            DIR_LEFT:  return 4'b0010;
            DIR_RIGHT: return 4'b0001;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// Synchronizes the raw PS/2 clock and data pins, shifts data in on each
// falling edge of the synchronized clock, checks start/parity/stop after
// the 11th bit, and aborts a partial frame after TIMEOUT_CYCLES of clock
// inactivity.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   ps2_clk     : raw PS/2 clock pin (asynchronous)
//   ps2_data    : raw PS/2 data pin (asynchronous)
//   byte_valid  : 1-cycle pulse, a well-formed byte was received
//   byte_data   : last good byte
//   frame_err   : 1-cycle pulse on start/parity/stop error or timeout
// Parameters:
//   TIMEOUT_CYCLES : idle clk cycles mid-frame before the frame is aborted
//   SYNC_STAGES    : synchronizer depth, legal values 2..3
module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] LAST_BIT = 4'd10;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [10:0]            shift_q, shift_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]          timeout_cnt_q, timeout_cnt_d;
    logic                   byte_valid_q, byte_valid_d;
    logic [7:0]             byte_data_q, byte_data_d;
    logic                   frame_err_q, frame_err_d;

    logic clk_s, data_s, fall, frame_ok;

    // NOTE: the PS/2 pins are asynchronous to clk, so nothing but the first
    // synchronizer flop may look at them directly.
    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    // Frame after the 11th shift: [0]=start, [8:1]=data, [9]=parity, [10]=stop
    assign frame_ok = ~shift_d[0] & shift_d[10] & (^shift_d[9:1]);

    // NOTE: every signal assigned here gets its default first so no path
    // leaves a value unassigned, which would infer a latch.
    always_comb begin
        clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d   = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d    = clk_s;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        byte_valid_d  = 1'b0;
        byte_data_d   = byte_data_q;
        frame_err_d   = 1'b0;

        if (fall) begin
            shift_d       = {data_s, shift_q[10:1]};
            timeout_cnt_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = 4'd0;
                if (frame_ok) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = shift_d[8:1];
                end else begin
                    frame_err_d  = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            // Stalled mid-frame: abort once the idle count reaches the limit
            if (timeout_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d     = 4'd0;
                timeout_cnt_d = '0;
                frame_err_d   = 1'b1;
            end else begin
                timeout_cnt_d = timeout_cnt_q + TW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the
    // synchronizers and edge history reset to the idle-high line level so
    // reset itself never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q    <= '1;
            data_sync_q   <= '1;
            clk_prev_q    <= 1'b1;
            shift_q       <= '0;
            bit_cnt_q     <= 4'd0;
            timeout_cnt_q <= '0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= 8'h00;
            frame_err_q   <= 1'b0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            clk_prev_q    <= clk_prev_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/pacman_ps2_input.sv
// PS/2 keyboard front end for pacman_controller.
// Receives scan codes through ps2_frame_rx and decodes extended arrow-key
// make/break sequences into a held, one-hot (or all-zero) direction level
// that follows the most recently pressed arrow key.
// Optional build macro PACMAN_WASD_EN: also decodes non-extended W/S/A/D
// makes and breaks as up/down/left/right.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   ps2_clk, ps2_data     : raw PS/2 pins (asynchronous)
//   up, down, left, right : registered direction levels
//   byte_valid, byte_data : received-byte strobe and value
//   frame_err             : 1-cycle pulse on a bad or timed-out frame
module pacman_ps2_input
    import pacman_input_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    logic        rx_valid;
    logic [7:0]  rx_data;

    scan_state_t state_q, state_d;
    dir_t        dir_q, dir_d;
    logic [3:0]  dirs_q, dirs_d;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (frame_err)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;

        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == SC_BRK) begin
                        state_d = ST_BRK;
`ifdef PACMAN_WASD_EN
                    end else if (wasd_dir(rx_data) != DIR_NONE) begin
                        dir_d = wasd_dir(rx_data);
`endif
                    end
                end
                ST_EXT: begin
                    if (rx_data == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        // A new make overrides any held key; anything else
                        // abandons the extended sequence.
                        if (arrow_dir(rx_data) != DIR_NONE) begin
                            dir_d = arrow_dir(rx_data);
                        end
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
`ifdef PACMAN_WASD_EN
                    if (wasd_dir(rx_data) != DIR_NONE && wasd_dir(rx_data) == dir_q) begin
                        dir_d = DIR_NONE;
                    end
`endif
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    // Releasing a key that is no longer current must not
                    // cancel the newer direction.
                    if (arrow_dir(rx_data) != DIR_NONE && arrow_dir(rx_data) == dir_q) begin
                        dir_d = DIR_NONE;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        dirs_d = dir_onehot(dir_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_NONE;
            dirs_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dirs_q  <= dirs_d;
        end
    end

    assign up         = dirs_q[3];
    assign down       = dirs_q[2];
    assign left       = dirs_q[1];
    assign right      = dirs_q[0];
    assign byte_valid = rx_valid;
    assign byte_data  = rx_data;

endmodule

// File: tb/tb_pacman_ps2_input.sv
// Directed testbench for pacman_ps2_input.
// The stimulus thread sends PS/2 frames and pushes, for each good byte, the
// expected byte plus the {up,down,left,right} level expected one cycle after
// its byte_valid. A monitor thread pops the scoreboard on each byte_valid.
module tb_pacman_ps2_input;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       up, down, left, right;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    logic [3:0] dirs;
    assign dirs = {up, down, left, right};

    typedef struct packed {
        logic [7:0] code;
        logic [3:0] dirs;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] cur_exp = 4'b0000;
    int         err_cnt = 0;
    int         tests   = 0;
    int         fails   = 0;

`ifdef PACMAN_WASD_EN
    localparam logic [3:0] WASD_UP_EXP = 4'b1000;
`else
    localparam logic [3:0] WASD_UP_EXP = 4'b0000;
`endif

    pacman_ps2_input #(
        .TIMEOUT_CYCLES (5000),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives the first nbits of a frame; ps2_clk period is 40 clk (20 high, 20 low)
    task automatic send_frame(input logic [7:0] data, input bit bad_parity, input int nbits);
        logic       p;
        logic [10:0] f;
        p = (~^data) ^ bad_parity;
        f = {1'b1, p, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (10) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(posedge clk);
        end
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic [3:0] exp_dirs);
        exp_t e;
        e.code = data;
        e.dirs = exp_dirs;
        sb.push_back(e);
        send_frame(data, 1'b0, 11);
    endtask

    // Monitor: compares each received byte and the direction level before and
    // one cycle after its byte_valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (frame_err) err_cnt++;
                check("onehot", 32'($countones(dirs) <= 1), 32'd1);
                if (byte_valid) begin
                    check("byte_valid_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("byte_data", 32'(byte_data), 32'(e.code));
                        check("dirs_hold_at_valid", 32'(dirs), 32'(cur_exp));
                        @(negedge clk);
                        if (frame_err) err_cnt++;
                        check("dirs_after_valid", 32'(dirs), 32'(e.dirs));
                        check("byte_valid_one_cycle", 32'(byte_valid), 32'd0);
                        cur_exp = e.dirs;
                    end
                end
            end
        end
    end

    initial begin
        int e0;

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_dirs", 32'(dirs), 32'd0);
        check("reset_byte_valid", 32'(byte_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_byte_data", 32'(byte_data), 32'h00);
        reset = 1'b0;
        repeat (10) @(posedge clk);

        // Left press and release
        send_byte(8'hE0, 4'b0000);
        send_byte(8'h6B, 4'b0010);
        send_byte(8'hE0, 4'b0010);
        send_byte(8'hF0, 4'b0010);
        send_byte(8'h6B, 4'b0000);

        // Up, then right without a break, then a stale up release
        send_byte(8'hE0, 4'b0000);
        send_byte(8'h75, 4'b1000);
        send_byte(8'hE0, 4'b1000);
        send_byte(8'h74, 4'b0001);
        send_byte(8'hE0, 4'b0001);
        send_byte(8'hF0, 4'b0001);
        send_byte(8'h75, 4'b0001);

        // Even parity frame: error pulse, no byte, outputs unchanged
        e0 = err_cnt;
        send_frame(8'h75, 1'b1, 11);
        check("parity_err_pulse", 32'(err_cnt - e0), 32'd1);
        check("parity_dirs", 32'(dirs), 32'b0001);
        check("parity_no_byte", 32'(sb.size()), 32'd0);

        // Partial frame then stall: timeout error
        e0 = err_cnt;
        send_frame(8'h72, 1'b0, 5);
        repeat (5100) @(posedge clk);
        check("timeout_err_pulse", 32'(err_cnt - e0), 32'd1);
        check("timeout_dirs", 32'(dirs), 32'b0001);

        // Receiver recovers after the timeout; typematic repeat holds down
        send_byte(8'hE0, 4'b0001);
        send_byte(8'h72, 4'b0100);
        send_byte(8'hE0, 4'b0100);
        send_byte(8'h72, 4'b0100);

        // Left held, then reset in the middle of its release
        send_byte(8'hE0, 4'b0100);
        send_byte(8'h6B, 4'b0010);
        send_byte(8'hE0, 4'b0010);
        send_byte(8'hF0, 4'b0010);
        send_frame(8'h6B, 1'b0, 5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midframe_reset_dirs", 32'(dirs), 32'd0);
        check("midframe_reset_scoreboard", 32'(sb.size()), 32'd0);
        reset   = 1'b0;
        cur_exp = 4'b0000;
        repeat (10) @(posedge clk);

        // WASD: only decoded when the feature is built in
        send_byte(8'h1D, WASD_UP_EXP);
        send_byte(8'hF0, WASD_UP_EXP);
        send_byte(8'h1D, 4'b0000);

        repeat (20) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("total_frame_errs", 32'(err_cnt), 32'd2);
        check("final_dirs", 32'(dirs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
